// File: rtl/subleq_mem_master.sv
// subleq_mem_master: sequences single-word core requests into strobe cycles on the async SUBLEQ RAM port
// Every output comes straight from a flop, so each state's RAM strobe pattern appears in the cycle the state is entered.
module subleq_mem_master #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int RD_WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_ope,
    output logic              ram_ctl,
    output logic              ram_ena,
    output logic [ADDR_W-1:0] ram_adr,
    inout  wire  [DATA_W-1:0] ram_dat
);
    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAX_SP > RD_WAIT) ? MAX_SP : RD_WAIT;
    localparam int CW     = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, R_DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n, dat_q;
    logic              dat_oe, accept, last, sample;

    assign ram_dat = dat_oe ? dat_q : {DATA_W{1'bz}};

    always_comb begin
        accept  = req_ready && req_valid;
        addr_n  = accept ? req_addr : addr_q;
        wdata_n = accept ? req_wdata : wdata_q;
        last    = (state == W_SETUP) ? (cnt == CW'(SETUP_CYC - 1)) :
                  (state == W_PULSE) ? (cnt == CW'(PULSE_CYC - 1)) :
                                       (cnt == CW'(RD_WAIT - 1));
        sample  = (state == R_ACCESS) && last;
        state_n = state;
        case (state)
            IDLE:     state_n = accept ? (req_we ? W_SETUP : R_ACCESS) : IDLE;
            W_SETUP:  state_n = last ? W_PULSE : W_SETUP;
            W_PULSE:  state_n = last ? W_HOLD : W_PULSE;
            W_HOLD:   state_n = IDLE;
            R_ACCESS: state_n = last ? R_DONE : R_ACCESS;
            R_DONE:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            ram_ope   <= 1'b1;
            ram_ctl   <= 1'b1;
            ram_ena   <= 1'b1;
            ram_adr   <= '0;
            dat_q     <= '0;
            dat_oe    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            req_ready <= state_n == IDLE;
            rsp_valid <= state_n == W_HOLD || state_n == R_DONE;
            ram_ope   <= state_n != R_ACCESS;
            ram_ctl   <= state_n != W_PULSE;
            // R_DONE releases ena together with ope so the bus turns around before any write drives it
            ram_ena   <= state_n == IDLE || state_n == R_DONE;
            ram_adr   <= (state_n == IDLE) ? '0 : addr_n;
            dat_q     <= wdata_n;
            dat_oe    <= state_n == W_SETUP || state_n == W_PULSE || state_n == W_HOLD;
            if (sample) rsp_rdata <= ram_dat;
        end
    end
endmodule

// File: tb/tb_subleq_mem_master.sv
// tb_subleq_mem_master: two masters (default and stretched timing) each on a behavioural async RAM,
// checked against an array reference memory plus latency formulas and bus-safety monitors.
module tb_subleq_mem_master;
    logic clk, rst, mon_en;
    logic v0, r0, we0, rv0, ope0, ctl0, ena0;
    logic v1, r1, we1, rv1, ope1, ctl1, ena1;
    logic [7:0] a0, d0, rd0, adr0, a1, d1, rd1, adr1;
    wire  [7:0] bus0, bus1;
    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ref_mem [256];
    int errors = 0, checks = 0, wr0 = 0, wr1 = 0;

    subleq_mem_master dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0), .req_we(we0), .req_addr(a0),
        .req_wdata(d0), .rsp_valid(rv0), .rsp_rdata(rd0), .ram_ope(ope0), .ram_ctl(ctl0),
        .ram_ena(ena0), .ram_adr(adr0), .ram_dat(bus0));

    subleq_mem_master #(.SETUP_CYC(2), .PULSE_CYC(3), .RD_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1), .req_we(we1), .req_addr(a1),
        .req_wdata(d1), .rsp_valid(rv1), .rsp_rdata(rd1), .ram_ope(ope1), .ram_ctl(ctl1),
        .ram_ena(ena1), .ram_adr(adr1), .ram_dat(bus1));

    assign bus0 = (!ena0 && !ope0) ? mem0[adr0] : 8'hzz;
    assign bus1 = (!ena1 && !ope1) ? mem1[adr1] : 8'hzz;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge ctl0) if (mon_en) begin
        if (ena0) begin errors++; $display("FAIL strobe0: ctl fell with ena=%0d, required 0", ena0); end
        mem0[adr0] = bus0;
        wr0++;
    end

    always @(negedge ctl1) if (mon_en) begin
        if (ena1) begin errors++; $display("FAIL strobe1: ctl fell with ena=%0d, required 0", ena1); end
        mem1[adr1] = bus1;
        wr1++;
    end

    always @(negedge clk) if (mon_en) begin
        if (!ope0 && dut0.dat_oe) begin errors++; $display("FAIL contention0: ope=0 while data driven"); end
        if (!ope1 && dut1.dat_oe) begin errors++; $display("FAIL contention1: ope=0 while data driven"); end
        if (!ctl0 && !ope0) begin errors++; $display("FAIL ctl_ope0: ctl=0 and ope=0 together"); end
        if (!ctl1 && !ope1) begin errors++; $display("FAIL ctl_ope1: ctl=0 and ope=0 together"); end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Issues one request on master s; lat counts cycles from the accept cycle to the rsp_valid cycle.
    task automatic txn(input bit s, input bit we, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd);
        int n = 0;
        @(negedge clk);
        if (s) begin v1 = 1; we1 = we; a1 = a; d1 = d; end
        else   begin v0 = 1; we0 = we; a0 = a; d0 = d; end
        while (!(s ? r1 : r0) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin errors++; $display("FAIL accept_timeout: got no ready, required ready"); end
        @(negedge clk);
        v0 = 0; v1 = 0;
        lat = 1;
        while (!(s ? rv1 : rv0) && lat < 50) begin @(negedge clk); lat++; end
        rd = s ? rd1 : rd0;
    endtask

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         lat;
    } vec_t;
    vec_t tab [6];

    initial begin
        int lat, w, acc, low;
        logic [7:0] rd, last_rd, d;
        tab[0] = '{1'b1, 8'h10, 8'hA5, 8'h00, 3};
        tab[1] = '{1'b0, 8'h10, 8'h00, 8'hA5, 3};
        tab[2] = '{1'b0, 8'h05, 8'h00, 8'h03, 3};
        tab[3] = '{1'b0, 8'h00, 8'h00, 8'h05, 3};
        tab[4] = '{1'b1, 8'h00, 8'h3C, 8'h05, 3};
        tab[5] = '{1'b0, 8'h00, 8'h00, 8'h3C, 3};
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
            ref_mem[i] = mem0[i];
        end
        mem0[5] = 8'h03; ref_mem[5] = 8'h03;
        mem0[0] = 8'h05; ref_mem[0] = 8'h05;
        mem0[8'h20] = 8'h11; ref_mem[8'h20] = 8'h11;
        mon_en = 0; rst = 1;
        v0 = 0; we0 = 0; a0 = 0; d0 = 0; v1 = 0; we1 = 0; a1 = 0; d1 = 0;
        repeat (3) @(negedge clk);
        rst = 0; mon_en = 1;
        @(negedge clk);
        chk("rst_ready", r0, 1); chk("rst_rsp_valid", rv0, 0); chk("rst_rdata", rd0, 0);
        chk("rst_ope", ope0, 1); chk("rst_ctl", ctl0, 1); chk("rst_ena", ena0, 1); chk("rst_adr", adr0, 0);

        for (int i = 0; i < 6; i++) begin
            w = wr0;
            txn(0, tab[i].we, tab[i].addr, tab[i].wdata, lat, rd);
            chk($sformatf("tab%0d_lat", i), lat, tab[i].lat);
            chk($sformatf("tab%0d_rdata", i), rd, tab[i].rdata);
            chk($sformatf("tab%0d_strobes", i), wr0 - w, int'(tab[i].we));
            if (tab[i].we) ref_mem[tab[i].addr] = tab[i].wdata;
        end

        // valid held high through a write: one accept, busy for setup+pulse+hold, re-accepted in IDLE
        @(negedge clk);
        v0 = 1; we0 = 1; a0 = 8'h40; d0 = 8'h5A; w = wr0; acc = 0; low = 0;
        for (int i = 0; i < 4; i++) begin
            if (v0 && r0) acc++;
            if (!r0) low++;
            @(negedge clk);
        end
        chk("hold_accepts", acc, 1);
        chk("hold_ready_low", low, 3);
        chk("hold_reaccept_ready", r0, 1);
        @(posedge clk);
        #1 v0 = 0;
        repeat (4) @(negedge clk);
        chk("hold_two_writes", wr0 - w, 2);
        ref_mem[8'h40] = 8'h5A;

        // reset during W_SETUP abandons the write before ctl can fall
        @(negedge clk);
        v0 = 1; we0 = 1; a0 = 8'h20; d0 = 8'h77; w = wr0;
        @(negedge clk);
        v0 = 0;
        chk("rstmid_setup_ena", ena0, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstmid_ready", r0, 1); chk("rstmid_ena", ena0, 1); chk("rstmid_ctl", ctl0, 1);
        chk("rstmid_rsp_valid", rv0, 0); chk("rstmid_rdata", rd0, 0);
        txn(0, 0, 8'h20, 8'h00, lat, rd);
        chk("rstmid_readback", rd, 8'h11);
        chk("rstmid_no_commit", wr0, w);
        last_rd = 8'h11;

        // stretched timing master at the top address
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            txn(1, 1, 8'hFF, d, lat, rd);
            chk($sformatf("p2_wlat%0d", k), lat, 6);
            txn(1, 0, 8'hFF, 8'h00, lat, rd);
            chk($sformatf("p2_rlat%0d", k), lat, 2);
            chk($sformatf("p2_rdata%0d", k), rd, d);
        end

        for (int k = 0; k < 40; k++) begin
            bit rwe = 1'($urandom);
            logic [7:0] ra = 8'($urandom), rdv = 8'($urandom);
            w = wr0;
            txn(0, rwe, ra, rdv, lat, rd);
            if (rwe) ref_mem[ra] = rdv;
            else last_rd = ref_mem[ra];
            chk($sformatf("rnd%0d_lat", k), lat, 3);
            chk($sformatf("rnd%0d_rdata", k), rd, last_rd);
            chk($sformatf("rnd%0d_strobes", k), wr0 - w, int'(rwe));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
